// File: rtl/vga_pkg.sv
// Shared types, default 640x480@60 timing and pixel-format helpers for the
// VGA window scaler.
package vga_pkg;

  localparam int H_ACTIVE_DEF = 640;
  localparam int H_FP_DEF     = 16;
  localparam int H_SYNC_DEF   = 96;
  localparam int H_BP_DEF     = 48;
  localparam int V_ACTIVE_DEF = 480;
  localparam int V_FP_DEF     = 10;
  localparam int V_SYNC_DEF   = 2;
  localparam int V_BP_DEF     = 33;

  localparam int PIX_RGB332 = 0;
  localparam int PIX_RGB444 = 1;

  typedef struct packed {
    logic [3:0] r;
    logic [3:0] g;
    logic [3:0] b;
  } rgb444_t;

  // Per-pixel side information that travels alongside the framebuffer read.
  typedef struct packed {
    logic hs;
    logic vs;
    logic vis;
    logic win;
    logic fs;
  } pix_tag_t;

  // MSB replication keeps full-scale 3-bit values at full-scale 4-bit values.
  function automatic rgb444_t expand332(input logic [7:0] p);
    rgb444_t c;
    c.r = {p[7:5], p[7]};
    c.g = {p[4:2], p[4]};
    c.b = {p[1:0], p[1:0]};
    return c;
  endfunction

endpackage

// File: rtl/vga_timing_core.sv
// Stage-0 raster counters with sync, visible-area and frame-boundary decode.
module vga_timing_core #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33
) (
  input  logic       clk25,
  input  logic       reset,
  output logic [9:0] h_o,
  output logic [9:0] v_o,
  output logic       hs_act_o,
  output logic       vs_act_o,
  output logic       visible_o,
  output logic       frame_start_o,
  output logic       frame_end_o
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  if (H_TOTAL > 1023 || V_TOTAL > 1023) begin : g_bad_total
    $fatal(1, "vga_timing_core: total line/frame length exceeds 10-bit counters");
  end

  localparam logic [9:0] H_LAST = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_VIS  = 10'(H_ACTIVE);
  localparam logic [9:0] V_VIS  = 10'(V_ACTIVE);
  localparam logic [9:0] HS_BEG = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] HS_END = 10'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [9:0] VS_BEG = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] VS_END = 10'(V_ACTIVE + V_FP + V_SYNC);

  logic [9:0] h_q, h_d;
  logic [9:0] v_q, v_d;

  always_comb begin
    h_d = h_q + 10'd1;
    v_d = v_q;
    if (h_q == H_LAST) begin
      h_d = '0;
      v_d = (v_q == V_LAST) ? '0 : v_q + 10'd1;
    end
  end

  always_ff @(posedge clk25) begin
    if (reset) begin
      h_q <= '0;
      v_q <= '0;
    end else begin
      h_q <= h_d;
      v_q <= v_d;
    end
  end

  assign h_o           = h_q;
  assign v_o           = v_q;
  assign hs_act_o      = (h_q >= HS_BEG) && (h_q < HS_END);
  assign vs_act_o      = (v_q >= VS_BEG) && (v_q < VS_END);
  assign visible_o     = (h_q < H_VIS) && (v_q < V_VIS);
  assign frame_start_o = (h_q == '0) && (v_q == '0);
  assign frame_end_o   = (h_q == H_LAST) && (v_q == V_LAST);

endmodule

// File: rtl/vga_window_scaler.sv
// VGA timing plus framebuffer readout of a replicated image window, with the
// sync/flag path delayed to match the address register, memory and output stage.
module vga_window_scaler
  import vga_pkg::*;
#(
  parameter int          H_ACTIVE   = H_ACTIVE_DEF,
  parameter int          H_FP       = H_FP_DEF,
  parameter int          H_SYNC     = H_SYNC_DEF,
  parameter int          H_BP       = H_BP_DEF,
  parameter int          V_ACTIVE   = V_ACTIVE_DEF,
  parameter int          V_FP       = V_FP_DEF,
  parameter int          V_SYNC     = V_SYNC_DEF,
  parameter int          V_BP       = V_BP_DEF,
  parameter int          HSYNC_POL  = 0,
  parameter int          VSYNC_POL  = 0,
  parameter int          IMG_W      = 320,
  parameter int          IMG_H      = 240,
  parameter int          WIN_X      = 160,
  parameter int          WIN_Y      = 120,
  parameter int          SCALE      = 1,
  parameter int          ADDR_W     = 17,
  parameter int          PIX_FMT    = PIX_RGB332,
  parameter int          RD_LAT     = 1,
  parameter logic [11:0] BORDER_RGB = 12'h000
) (
  input  logic                                        clk25,
  input  logic                                        reset,
  output logic [ADDR_W-1:0]                           frame_addr,
  input  logic [((PIX_FMT == PIX_RGB444) ? 12 : 8)-1:0] frame_pixel,
  output logic [3:0]                                  vga_red,
  output logic [3:0]                                  vga_green,
  output logic [3:0]                                  vga_blue,
  output logic                                        vga_hsync,
  output logic                                        vga_vsync,
  output logic [9:0]                                  HCnt,
  output logic [9:0]                                  VCnt,
  output logic                                        frame_start
);

  if (SCALE < 1 || SCALE > 4) begin : g_bad_scale
    $fatal(1, "vga_window_scaler: SCALE must be 1..4");
  end
  if (RD_LAT < 1 || RD_LAT > 3) begin : g_bad_lat
    $fatal(1, "vga_window_scaler: RD_LAT must be 1..3");
  end
  if (PIX_FMT != PIX_RGB332 && PIX_FMT != PIX_RGB444) begin : g_bad_fmt
    $fatal(1, "vga_window_scaler: unknown PIX_FMT");
  end
  if (WIN_X + IMG_W * SCALE > H_ACTIVE || WIN_Y + IMG_H * SCALE > V_ACTIVE) begin : g_bad_win
    $fatal(1, "vga_window_scaler: window does not fit on screen");
  end
  if (ADDR_W > 30 || IMG_W * IMG_H > (1 << ADDR_W)) begin : g_bad_addr
    $fatal(1, "vga_window_scaler: image does not fit in ADDR_W");
  end

  localparam logic [9:0]        WX0     = 10'(WIN_X);
  localparam logic [9:0]        WX1     = 10'(WIN_X + IMG_W * SCALE);
  localparam logic [9:0]        WX_LAST = 10'(WIN_X + IMG_W * SCALE - 1);
  localparam logic [9:0]        WY0     = 10'(WIN_Y);
  localparam logic [9:0]        WY1     = 10'(WIN_Y + IMG_H * SCALE);
  localparam logic [1:0]        SC_LAST = 2'(SCALE - 1);
  localparam logic [ADDR_W-1:0] ROW_INC = ADDR_W'(IMG_W);
  localparam logic              HS_ON   = 1'(HSYNC_POL);
  localparam logic              VS_ON   = 1'(VSYNC_POL);

  logic [9:0] h, v;
  logic       hs_act, vs_act, visible, fs0, frame_end;

  vga_timing_core #(
    .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
    .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP)
  ) u_timing (
    .clk25        (clk25),
    .reset        (reset),
    .h_o          (h),
    .v_o          (v),
    .hs_act_o     (hs_act),
    .vs_act_o     (vs_act),
    .visible_o    (visible),
    .frame_start_o(fs0),
    .frame_end_o  (frame_end)
  );

  logic in_win, win_line_end;
  assign in_win       = (h >= WX0) && (h < WX1) && (v >= WY0) && (v < WY1);
  assign win_line_end = in_win && (h == WX_LAST);

  logic [1:0]        sx_q, sx_d, sy_q, sy_d;
  logic [ADDR_W-1:0] col_addr_q, col_addr_d, row_base_q, row_base_d;
  logic [ADDR_W-1:0] frame_addr_q, frame_addr_d;

  // Replication is done by sub-counters so the address never needs a multiplier.
  always_comb begin
    sx_d         = sx_q;
    sy_d         = sy_q;
    col_addr_d   = col_addr_q;
    row_base_d   = row_base_q;
    frame_addr_d = in_win ? (row_base_q + col_addr_q) : '0;
    if (frame_end) begin
      sx_d       = '0;
      sy_d       = '0;
      col_addr_d = '0;
      row_base_d = '0;
    end else if (win_line_end) begin
      sx_d       = '0;
      col_addr_d = '0;
      if (sy_q == SC_LAST) begin
        sy_d       = '0;
        row_base_d = row_base_q + ROW_INC;
      end else begin
        sy_d = sy_q + 2'd1;
      end
    end else if (in_win) begin
      if (sx_q == SC_LAST) begin
        sx_d       = '0;
        col_addr_d = col_addr_q + ADDR_W'(1);
      end else begin
        sx_d = sx_q + 2'd1;
      end
    end
  end

  always_ff @(posedge clk25) begin
    if (reset) begin
      sx_q         <= '0;
      sy_q         <= '0;
      col_addr_q   <= '0;
      row_base_q   <= '0;
      frame_addr_q <= '0;
    end else begin
      sx_q         <= sx_d;
      sy_q         <= sy_d;
      col_addr_q   <= col_addr_d;
      row_base_q   <= row_base_d;
      frame_addr_q <= frame_addr_d;
    end
  end

  assign frame_addr = frame_addr_q;

  pix_tag_t tag0;
  pix_tag_t tag_q [0:RD_LAT];

  always_comb begin
    tag0     = '0;
    tag0.hs  = hs_act;
    tag0.vs  = vs_act;
    tag0.vis = visible;
    tag0.win = in_win;
    tag0.fs  = fs0;
  end

  // Entry RD_LAT lines up with frame_pixel; the output register adds the last stage.
  always_ff @(posedge clk25) begin
    if (reset) begin
      for (int i = 0; i <= RD_LAT; i++) tag_q[i] <= '0;
    end else begin
      tag_q[0] <= tag0;
      for (int i = 1; i <= RD_LAT; i++) tag_q[i] <= tag_q[i-1];
    end
  end

  pix_tag_t    tap;
  logic [11:0] pix_wide;
  rgb444_t     rgb_d, rgb_q;
  logic        hsync_q, vsync_q, fs_q;

  assign tap      = tag_q[RD_LAT];
  assign pix_wide = 12'(frame_pixel);

  always_comb begin
    rgb_d = '0;
    if (tap.win) begin
      rgb_d = (PIX_FMT == PIX_RGB444) ? rgb444_t'(pix_wide) : expand332(pix_wide[7:0]);
    end else if (tap.vis) begin
      rgb_d = rgb444_t'(BORDER_RGB);
    end
  end

  always_ff @(posedge clk25) begin
    if (reset) begin
      rgb_q   <= '0;
      hsync_q <= ~HS_ON;
      vsync_q <= ~VS_ON;
      fs_q    <= 1'b0;
    end else begin
      rgb_q   <= rgb_d;
      hsync_q <= tap.hs ? HS_ON : ~HS_ON;
      vsync_q <= tap.vs ? VS_ON : ~VS_ON;
      fs_q    <= tap.fs;
    end
  end

  assign vga_red     = rgb_q.r;
  assign vga_green   = rgb_q.g;
  assign vga_blue    = rgb_q.b;
  assign vga_hsync   = hsync_q;
  assign vga_vsync   = vsync_q;
  assign frame_start = fs_q;
  assign HCnt        = h;
  assign VCnt        = v;

endmodule

// File: tb/tb_vga_window_scaler.sv
// Scoreboard bench for vga_window_scaler on a shrunken 24x17 raster:
// config 0 = RGB332, SCALE 1, offset window; config 1 = RGB444, SCALE 2, full screen.
module tb_vga_window_scaler;

  localparam int HA = 16, HF = 2, HS = 3, HB = 3;
  localparam int VA = 12, VF = 1, VS = 2, VB = 2;
  localparam int HT = 24, VT = 17, FRAME = 408;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_cmp = 0;
  int   n_bad = 0;
  int   n_dir_hits = 0;

  always #5 clk = ~clk;

  typedef struct {
    int due;
    int h;
    int v;
    int addr;
  } addr_rec_t;

  typedef struct {
    int          due;
    int          h;
    int          v;
    logic [11:0] rgb;
    logic        hs;
    logic        vs;
    logic        fs;
  } pix_rec_t;

  typedef struct {
    int cfg;
    int kind;  // 0: frame_addr one cycle after (h,v); 1: RGB PIPE cycles after (h,v)
    int h;
    int v;
    int val;
  } dir_t;

  dir_t dirs[$];

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [11:0] memf(input int cfg, input int addr);
    if (cfg == 0) return (addr == 20) ? 12'h0E3 : 12'(addr & 255);
    return (addr == 13) ? 12'hA5C : {4'(addr) ^ 4'h3, 4'(addr), ~4'(addr)};
  endfunction

  function automatic logic [11:0] exp332(input logic [7:0] p);
    int r, g, b;
    r = int'(p) / 32;
    g = (int'(p) / 4) % 8;
    b = int'(p) % 4;
    return 12'(((r * 2 + r / 4) << 8) | ((g * 2 + g / 4) << 4) | (b * 5));
  endfunction

  for (genvar G = 0; G < 2; G++) begin : g_cfg
    localparam int          S    = (G == 0) ? 1 : 2;
    localparam int          WX   = (G == 0) ? 4 : 0;
    localparam int          WY   = (G == 0) ? 3 : 0;
    localparam int          IW   = 8;
    localparam int          IH   = 6;
    localparam int          RL   = (G == 0) ? 1 : 3;
    localparam int          FMT  = G;
    localparam int          HPOL = G;
    localparam int          VPOL = 0;
    localparam logic [11:0] BORD = (G == 0) ? 12'h5A3 : 12'h000;
    localparam int          PIPE = RL + 2;
    localparam int          PW   = (FMT == 1) ? 12 : 8;

    logic [7:0]    faddr;
    logic [PW-1:0] fpix;
    logic [3:0]    r, gr, b;
    logic          hsy, vsy, fst;
    logic [9:0]    hc, vc;
    logic [11:0]   mem_q [0:2];

    vga_window_scaler #(
      .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
      .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
      .HSYNC_POL(HPOL), .VSYNC_POL(VPOL),
      .IMG_W(IW), .IMG_H(IH), .WIN_X(WX), .WIN_Y(WY), .SCALE(S),
      .ADDR_W(8), .PIX_FMT(FMT), .RD_LAT(RL), .BORDER_RGB(BORD)
    ) u_dut (
      .clk25      (clk),
      .reset      (rst),
      .frame_addr (faddr),
      .frame_pixel(fpix),
      .vga_red    (r),
      .vga_green  (gr),
      .vga_blue   (b),
      .vga_hsync  (hsy),
      .vga_vsync  (vsy),
      .HCnt       (hc),
      .VCnt       (vc),
      .frame_start(fst)
    );

    // Framebuffer with RL cycles of read latency.
    always @(posedge clk) begin
      mem_q[0] <= memf(G, int'(faddr));
      mem_q[1] <= mem_q[0];
      mem_q[2] <= mem_q[1];
    end
    assign fpix = PW'(mem_q[RL-1]);

    int        cyc = 0;
    int        mh = 0, mv = 0;
    addr_rec_t qa[$];
    pix_rec_t  qp[$];
    int        n_period = 0;

    always @(posedge clk) begin : model
      addr_rec_t   ar;
      pix_rec_t    pr;
      logic        vis, win;
      int          a;
      logic [11:0] d;
      cyc++;
      if (rst) begin
        mh = 0;
        mv = 0;
        qa.delete();
        qp.delete();
        ar = '{cyc, -1, -1, 0};
        qa.push_back(ar);
        for (int k = 0; k < PIPE; k++) begin
          pr = '{cyc + k, -1, -1, 12'h000, 1'(1 - HPOL), 1'(1 - VPOL), 1'b0};
          qp.push_back(pr);
        end
      end else if (mh == HT - 1) begin
        mh = 0;
        mv = (mv == VT - 1) ? 0 : mv + 1;
      end else begin
        mh++;
      end
      vis = (mh < HA) && (mv < VA);
      win = (mh >= WX) && (mh < WX + IW * S) && (mv >= WY) && (mv < WY + IH * S);
      a   = win ? ((mv - WY) / S) * IW + (mh - WX) / S : 0;
      d   = memf(G, a);
      ar  = '{cyc + 1, mh, mv, a};
      qa.push_back(ar);
      pr.due = cyc + PIPE;
      pr.h   = mh;
      pr.v   = mv;
      pr.rgb = win ? ((FMT == 1) ? d : exp332(d[7:0])) : (vis ? BORD : 12'h000);
      pr.hs  = ((mh >= HA + HF) && (mh < HA + HF + HS)) ? 1'(HPOL) : 1'(1 - HPOL);
      pr.vs  = ((mv >= VA + VF) && (mv < VA + VF + VS)) ? 1'(VPOL) : 1'(1 - VPOL);
      pr.fs  = (mh == 0) && (mv == 0);
      qp.push_back(pr);
    end

    int last_fs = 0, hs_n = 0, vs_n = 0;
    bit have_fs = 1'b0;

    always @(negedge clk) begin : monitor
      addr_rec_t ar;
      pix_rec_t  pr;
      if (cyc > 0) begin
        chk($sformatf("c%0d_hcnt", G), int'(hc), mh);
        chk($sformatf("c%0d_vcnt", G), int'(vc), mv);
      end
      while (qa.size() > 0 && qa[0].due <= cyc) begin
        ar = qa.pop_front();
        chk($sformatf("c%0d_addr_due", G), ar.due, cyc);
        chk($sformatf("c%0d_addr(%0d,%0d)", G, ar.h, ar.v), int'(faddr), ar.addr);
        foreach (dirs[i]) begin
          if (dirs[i].cfg == G && dirs[i].kind == 0 && dirs[i].h == ar.h && dirs[i].v == ar.v) begin
            n_dir_hits++;
            chk($sformatf("c%0d_dir_addr(%0d,%0d)", G, ar.h, ar.v), int'(faddr), dirs[i].val);
          end
        end
      end
      while (qp.size() > 0 && qp[0].due <= cyc) begin
        pr = qp.pop_front();
        chk($sformatf("c%0d_pix_due", G), pr.due, cyc);
        chk($sformatf("c%0d_rgb(%0d,%0d)", G, pr.h, pr.v), int'({r, gr, b}), int'(pr.rgb));
        chk($sformatf("c%0d_hsync(%0d,%0d)", G, pr.h, pr.v), int'(hsy), int'(pr.hs));
        chk($sformatf("c%0d_vsync(%0d,%0d)", G, pr.h, pr.v), int'(vsy), int'(pr.vs));
        chk($sformatf("c%0d_fstart(%0d,%0d)", G, pr.h, pr.v), int'(fst), int'(pr.fs));
        foreach (dirs[i]) begin
          if (dirs[i].cfg == G && dirs[i].kind == 1 && dirs[i].h == pr.h && dirs[i].v == pr.v) begin
            n_dir_hits++;
            chk($sformatf("c%0d_dir_rgb(%0d,%0d)", G, pr.h, pr.v), int'({r, gr, b}), dirs[i].val);
          end
        end
      end
      if (rst) begin
        have_fs = 1'b0;
      end else begin
        if (fst) begin
          if (have_fs) begin
            n_period++;
            chk($sformatf("c%0d_frame_period", G), cyc - last_fs, FRAME);
            chk($sformatf("c%0d_hsync_cycles", G), hs_n, 51);
            chk($sformatf("c%0d_vsync_cycles", G), vs_n, 48);
          end
          have_fs = 1'b1;
          last_fs = cyc;
          hs_n    = 0;
          vs_n    = 0;
        end
        if (hsy == 1'(HPOL)) hs_n++;
        if (vsy == 1'(VPOL)) vs_n++;
      end
    end
  end

  initial begin
    // Config 0: RGB332, window at (4,3), border 5A3, memory = addr except 20 -> E3.
    dirs.push_back('{0, 0,  4,  3, 0});
    dirs.push_back('{0, 0, 11,  3, 7});
    dirs.push_back('{0, 0,  4,  4, 8});
    dirs.push_back('{0, 0, 11,  8, 47});
    dirs.push_back('{0, 0, 12,  3, 0});
    dirs.push_back('{0, 1,  5,  3, 'h005});
    dirs.push_back('{0, 1,  6,  4, 'h04A});
    dirs.push_back('{0, 1,  8,  5, 'hF0F});
    dirs.push_back('{0, 1, 11,  8, 'h26F});
    dirs.push_back('{0, 1,  0,  5, 'h5A3});
    dirs.push_back('{0, 1,  3,  3, 'h5A3});
    dirs.push_back('{0, 1, 20,  5, 'h000});
    dirs.push_back('{0, 1,  4, 12, 'h000});
    // Config 1: RGB444, SCALE 2, full screen, address 13 -> A5C.
    dirs.push_back('{1, 0,  0,  0, 0});
    dirs.push_back('{1, 0,  1,  0, 0});
    dirs.push_back('{1, 0,  2,  0, 1});
    dirs.push_back('{1, 0,  3,  0, 1});
    dirs.push_back('{1, 0, 15,  0, 7});
    dirs.push_back('{1, 0,  0,  1, 0});
    dirs.push_back('{1, 0,  3,  1, 1});
    dirs.push_back('{1, 0,  0,  2, 8});
    dirs.push_back('{1, 0, 15, 11, 47});
    dirs.push_back('{1, 1,  2,  0, 'h21E});
    dirs.push_back('{1, 1,  0,  2, 'hB87});
    dirs.push_back('{1, 1, 10,  2, 'hA5C});
    dirs.push_back('{1, 1, 11,  3, 'hA5C});

    rst = 1'b1;
    repeat (4) @(negedge clk);
    rst = 1'b0;
    repeat (2 * FRAME + 6 * HT + 10) @(negedge clk);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (3 * FRAME) @(negedge clk);

    chk("c0_period_checks_seen", int'(g_cfg[0].n_period >= 4), 1);
    chk("c1_period_checks_seen", int'(g_cfg[1].n_period >= 4), 1);
    chk("directed_hits", int'(n_dir_hits >= 2 * dirs.size()), 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
